// File: rtl/sig_link_pkg.sv
// Shared types and helpers for the OutSignal -> InSignal link buffer.
package sig_link_pkg;

    localparam int unsigned SIG_BUS_W = 3;

    typedef struct packed {
        logic                 flag;
        logic [SIG_BUS_W-1:0] bus;
    } sig_word_t;

    // Pointer width that stays at least one bit for tiny depths.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sig_link_ram.sv
// Register-array storage: one synchronous write port, asynchronous read.
module sig_link_ram
    import sig_link_pkg::*;
#(
    parameter int unsigned WORD_W = SIG_BUS_W + 1,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_data_o = mem_q[raddr_i];

endmodule

// File: rtl/sig_link_fifo.sv
// Elastic valid/ready buffer for {flag, bus} words with show-ahead head
// output, fill level and high-water mark.
module sig_link_fifo
    import sig_link_pkg::*;
#(
    parameter int unsigned DATA_W = SIG_BUS_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_bus,
    input  logic              wr_flag,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_bus,
    output logic              rd_flag,
    output logic [CNT_W-1:0]  level,
    output logic [CNT_W-1:0]  high_water
);

    localparam int unsigned PTR_W  = clog2_min1(DEPTH);
    localparam int unsigned WORD_W = DATA_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d, hw_q, hw_d;
    logic              wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] head_q, head_d, wr_word, ram_word;
    logic              push, pop;

    assign wr_word = {wr_flag, wr_bus};
    assign push    = wr_valid && wr_ready_q;
    assign pop     = rd_valid_q && rd_ready;

    sig_link_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (push && !flush),
        .waddr_i   (wr_ptr_q),
        .wdata_i   (wr_word),
        .raddr_i   (rd_ptr_d),
        .rd_data_o (ram_word)
    );

    // Next-state: pointers, level, high-water and the registered head word.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        hw_d     = hw_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            hw_d     = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + CNT_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - CNT_W'(1);
            end
            if (level_d > hw_q) begin
                hw_d = level_d;
            end
            // The new head may be the word being written on this very edge.
            if (level_d != '0) begin
                head_d = (push && (wr_ptr_q == rd_ptr_d)) ? wr_word : ram_word;
            end
        end
        wr_ready_d = (level_d != CNT_W'(DEPTH));
        rd_valid_d = (level_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            hw_q       <= '0;
            head_q     <= '0;
            wr_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            hw_q       <= hw_d;
            head_q     <= head_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign rd_valid   = rd_valid_q;
    assign rd_bus     = head_q[DATA_W-1:0];
    assign rd_flag    = head_q[DATA_W];
    assign level      = level_q;
    assign high_water = hw_q;

endmodule

// File: tb/tb_sig_link_fifo.sv
// Self-checking bench for sig_link_fifo against a queue-based reference model.
module tb_sig_link_fifo;
    import sig_link_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n, flush, wr_valid, wr_ready, wr_flag;
    logic             rd_valid, rd_ready, rd_flag;
    logic [2:0]       wr_bus, rd_bus;
    logic [CNT_W-1:0] level, high_water;

    int        errors = 0;
    int        checks = 0;
    sig_word_t mq[$];
    int        m_hw = 0;

    always #5 clk = ~clk;

    sig_link_fifo #(.DATA_W(3), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_bus     (wr_bus),
        .wr_flag    (wr_flag),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_bus     (rd_bus),
        .rd_flag    (rd_flag),
        .level      (level),
        .high_water (high_water)
    );

    // Drive one cycle of inputs, advance one edge, update the model from the handshake rules.
    task automatic tick(input bit wv, input logic [2:0] b, input logic f, input bit rr, input bit fl);
        bit do_push, do_pop;
        wr_valid = wv; wr_bus = b; wr_flag = f; rd_ready = rr; flush = fl;
        do_push = wv && (mq.size() != DEPTH);
        do_pop  = rr && (mq.size() != 0);
        @(posedge clk);
        if (!rst_n || fl) begin
            mq.delete();
            m_hw = 0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{flag: f, bus: b});
            if (mq.size() > m_hw) m_hw = mq.size();
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_n = 1'b1;
            tick(0, 3'd0, 1'b0, 0, 0);
            checks++;
            if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || level !== '0 || high_water !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: wr_ready=%b rd_valid=%b level=%0d hw=%0d, required 1 0 0 0",
                         i, wr_ready, rd_valid, level, high_water);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [2:0] eb;
        for (int i = 0; i < 4; i++) begin
            eb = 3'(i + 1);
            tick(1, eb, logic'(i % 2), 0, 0);
            checks++;
            if (level !== CNT_W'(i + 1)) begin
                errors++;
                $display("FAIL fill_level push=%0d: got %0d, required %0d", i, level, i + 1);
            end
        end
        tick(0, 3'd0, 1'b0, 0, 0);
        checks++;
        if (wr_ready !== 1'b0 || level !== CNT_W'(4) || high_water !== CNT_W'(4)) begin
            errors++;
            $display("FAIL fill_full: wr_ready=%b level=%0d hw=%0d, required 0 4 4", wr_ready, level, high_water);
        end
        for (int i = 0; i < 4; i++) begin
            eb = 3'(i + 1);
            checks++;
            if (rd_valid !== 1'b1 || rd_bus !== eb || rd_flag !== logic'(i % 2)) begin
                errors++;
                $display("FAIL drain_word %0d: valid=%b bus=%0d flag=%b, required 1 %0d %0d",
                         i, rd_valid, rd_bus, rd_flag, eb, i % 2);
            end
            tick(0, 3'd0, 1'b0, 1, 0);
        end
        checks++;
        if (rd_valid !== 1'b0 || level !== '0 || high_water !== CNT_W'(4)) begin
            errors++;
            $display("FAIL drain_empty: rd_valid=%b level=%0d hw=%0d, required 0 0 4", rd_valid, level, high_water);
        end
    endtask

    task automatic test_full_boundary();
        logic [2:0] exp_bus [4];
        logic [2:0] eb;
        for (int i = 0; i < 4; i++) tick(1, 3'(i + 1), 1'b0, 0, 0);
        tick(1, 3'd5, 1'b1, 1, 0);
        checks++;
        if (level !== CNT_W'(3) || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d wr_ready=%b, required 3 1", level, wr_ready);
        end
        tick(1, 3'd5, 1'b1, 0, 0);
        checks++;
        if (level !== CNT_W'(4)) begin
            errors++;
            $display("FAIL full_retry: level=%0d, required 4", level);
        end
        exp_bus[0] = 3'd2; exp_bus[1] = 3'd3; exp_bus[2] = 3'd4; exp_bus[3] = 3'd5;
        for (int i = 0; i < 4; i++) begin
            eb = exp_bus[i];
            checks++;
            if (rd_valid !== 1'b1 || rd_bus !== eb || rd_flag !== logic'(i == 3)) begin
                errors++;
                $display("FAIL full_order %0d: valid=%b bus=%0d flag=%b, required 1 %0d %0d",
                         i, rd_valid, rd_bus, rd_flag, eb, i == 3);
            end
            tick(0, 3'd0, 1'b0, 1, 0);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        for (int i = 0; i < 21; i++) begin
            if (rd_valid === 1'b1) begin
                checks++;
                if (rd_bus !== 3'(got % 8) || rd_flag !== logic'(got % 2)) begin
                    errors++;
                    $display("FAIL stream_word %0d: bus=%0d flag=%b, required %0d %0d",
                             got, rd_bus, rd_flag, got % 8, got % 2);
                end
                got++;
            end
            checks++;
            if (level > CNT_W'(1) || wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_level cyc=%0d: level=%0d wr_ready=%b, required <=1 1", i, level, wr_ready);
            end
            if (i < 20) tick(1, 3'(i % 8), logic'(i % 2), 1, 0);
            else        tick(0, 3'd0, 1'b0, 1, 0);
        end
        checks++;
        if (got != 20 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: got %0d words valid=%b, required 20 0", got, rd_valid);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) tick(1, 3'(i), 1'b0, 0, 0);
        checks++;
        if (level !== CNT_W'(3)) begin
            errors++;
            $display("FAIL flush_pre: level=%0d, required 3", level);
        end
        tick(1, 3'd7, 1'b1, 0, 1);
        checks++;
        if (level !== '0 || rd_valid !== 1'b0 || high_water !== '0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: level=%0d valid=%b hw=%0d wr_ready=%b, required 0 0 0 1",
                     level, rd_valid, high_water, wr_ready);
        end
        tick(1, 3'd6, 1'b0, 0, 0);
        checks++;
        if (rd_valid !== 1'b1 || rd_bus !== 3'd6 || rd_flag !== 1'b0 || level !== CNT_W'(1) || high_water !== CNT_W'(1)) begin
            errors++;
            $display("FAIL flush_after: valid=%b bus=%0d flag=%b level=%0d hw=%0d, required 1 6 0 1 1",
                     rd_valid, rd_bus, rd_flag, level, high_water);
        end
        tick(0, 3'd0, 1'b0, 1, 0);
    endtask

    task automatic test_async_reset();
        tick(1, 3'd1, 1'b0, 0, 0);
        tick(1, 3'd2, 1'b1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || level !== '0 || high_water !== '0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b level=%0d hw=%0d wr_ready=%b, required 0 0 0 1",
                     rd_valid, level, high_water, wr_ready);
        end
        tick(1, 3'd3, 1'b0, 1, 0);
        checks++;
        if (level !== '0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: level=%0d valid=%b, required 0 0", level, rd_valid);
        end
        rst_n = 1'b1;
        tick(0, 3'd0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (rd_valid !== (mq.size() != 0) || level !== CNT_W'(mq.size()) ||
                wr_ready !== (mq.size() != DEPTH) || high_water !== CNT_W'(m_hw)) begin
                errors++;
                $display("FAIL rand_state cyc=%0d: valid=%b level=%0d wr_ready=%b hw=%0d, required %b %0d %b %0d",
                         i, rd_valid, level, wr_ready, high_water,
                         mq.size() != 0, mq.size(), mq.size() != DEPTH, m_hw);
            end
            if (mq.size() != 0) begin
                checks++;
                if (rd_bus !== mq[0].bus || rd_flag !== mq[0].flag) begin
                    errors++;
                    $display("FAIL rand_head cyc=%0d: bus=%0d flag=%b, required %0d %b",
                             i, rd_bus, rd_flag, mq[0].bus, mq[0].flag);
                end
            end
            tick(bit'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 40) == 0));
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_bus = 3'd0; wr_flag = 1'b0; rd_ready = 1'b0;
        #1;
        test_reset();
        test_fill_drain();
        test_full_boundary();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
